// File: rtl/msrv32_imm_encoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : msrv32_imm_encoder_if
// Description : Stream and counter signals of the RV32 immediate encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface msrv32_imm_encoder_if #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
);
    logic [31:0]      instr_in;
    logic [31:0]      imm_in;
    logic [2:0]       imm_type_in;
    logic             in_valid_in;
    logic             in_ready_out;
    logic [31:0]      instr_out;
    logic             range_err_out;
    logic             out_valid_out;
    logic             out_ready_in;
    logic             cnt_clr_in;
    logic [CNT_W-1:0] enc_count_out;
    logic [ERR_W-1:0] err_count_out;

    modport master (
        output instr_in, imm_in, imm_type_in, in_valid_in, out_ready_in, cnt_clr_in,
        input  in_ready_out, instr_out, range_err_out, out_valid_out,
               enc_count_out, err_count_out
    );

    modport slave (
        input  instr_in, imm_in, imm_type_in, in_valid_in, out_ready_in, cnt_clr_in,
        output in_ready_out, instr_out, range_err_out, out_valid_out,
               enc_count_out, err_count_out
    );
endinterface
`default_nettype wire

// File: rtl/msrv32_imm_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : msrv32_imm_encoder
// Description : Inserts an immediate into an RV32 instruction word (streaming,
//               2-entry skid buffer, range flag, beat/error counters).
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_imm_encoder #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  wire logic              ms_riscv32_mp_clk_in,
    input  wire logic              ms_riscv32_mp_rst_in,
    msrv32_imm_encoder_if.slave    bus
);

    localparam logic [2:0] c_TYPE_I0  = 3'b000;
    localparam logic [2:0] c_TYPE_I1  = 3'b001;
    localparam logic [2:0] c_TYPE_S   = 3'b010;
    localparam logic [2:0] c_TYPE_B   = 3'b011;
    localparam logic [2:0] c_TYPE_U   = 3'b100;
    localparam logic [2:0] c_TYPE_J   = 3'b101;
    localparam logic [2:0] c_TYPE_CSR = 3'b110;

    logic [31:0]      w_enc;
    logic             w_err;
    logic             w_in_xfer;
    logic             w_out_xfer;

    logic [31:0]      r_out_instr;
    logic             r_out_err;
    logic             r_out_valid;
    logic [31:0]      r_skid_instr;
    logic             r_skid_err;
    logic             r_skid_valid;
    logic [CNT_W-1:0] r_enc_cnt;
    logic [ERR_W-1:0] r_err_cnt;

    wire logic [31:0] w_imm = bus.imm_in;
    wire logic [31:0] w_ins = bus.instr_in;

    // A value fits an N-bit signed field when all bits above the field's MSB equal it.
    wire logic w_fit12 = (&w_imm[31:11]) | ~(|w_imm[31:11]);
    wire logic w_fit13 = (&w_imm[31:12]) | ~(|w_imm[31:12]);
    wire logic w_fit21 = (&w_imm[31:20]) | ~(|w_imm[31:20]);

    always_comb begin
        w_enc = w_ins;
        w_err = 1'b0;
        case (bus.imm_type_in)
            c_TYPE_S: begin
                w_enc = {w_imm[11:5], w_ins[24:12], w_imm[4:0], w_ins[6:0]};
                w_err = ~w_fit12;
            end
            c_TYPE_B: begin
                w_enc = {w_imm[12], w_imm[10:5], w_ins[24:12], w_imm[4:1], w_imm[11], w_ins[6:0]};
                w_err = ~w_fit13 | w_imm[0];
            end
            c_TYPE_U: begin
                w_enc = {w_imm[31:12], w_ins[11:0]};
                w_err = |w_imm[11:0];
            end
            c_TYPE_J: begin
                w_enc = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], w_ins[11:0]};
                w_err = ~w_fit21 | w_imm[0];
            end
            c_TYPE_CSR: begin
                w_enc = {w_ins[31:20], w_imm[4:0], w_ins[14:0]};
                w_err = |w_imm[31:5];
            end
            c_TYPE_I0, c_TYPE_I1: begin
                w_enc = {w_imm[11:0], w_ins[19:0]};
                w_err = ~w_fit12;
            end
            default: begin
                w_enc = {w_imm[11:0], w_ins[19:0]};
                w_err = ~w_fit12;
            end
        endcase
    end

    // Ready is simply "skid empty"; the skid flop itself is the registered ready.
    assign w_in_xfer  = bus.in_valid_in & ~r_skid_valid;
    assign w_out_xfer = r_out_valid & bus.out_ready_in;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_out_instr  <= 32'h0;
            r_out_err    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_skid_instr <= 32'h0;
            r_skid_err   <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            if (w_out_xfer) begin
                r_out_instr  <= r_skid_instr;
                r_out_err    <= r_skid_err;
                r_skid_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            if (!r_out_valid || w_out_xfer) begin
                r_out_instr <= w_enc;
                r_out_err   <= w_err;
                r_out_valid <= 1'b1;
            end else begin
                r_skid_instr <= w_enc;
                r_skid_err   <= w_err;
                r_skid_valid <= 1'b1;
            end
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in || bus.cnt_clr_in) begin
            r_enc_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_in_xfer) begin
            r_enc_cnt <= r_enc_cnt + CNT_W'(1);
            if (w_err && (r_err_cnt != {ERR_W{1'b1}}))
                r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign bus.in_ready_out  = ~r_skid_valid;
    assign bus.instr_out     = r_out_instr;
    assign bus.range_err_out = r_out_err;
    assign bus.out_valid_out = r_out_valid;
    assign bus.enc_count_out = r_enc_cnt;
    assign bus.err_count_out = r_err_cnt;

endmodule
`default_nettype wire
